// File: rtl/dma_pkg.sv
// Shared definitions for the DMA address-generator family: FSM encoding,
// default widths and s_last bit positions.
package dma_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dma_state_e;

  localparam int DMA_AW  = 14;
  localparam int DMA_STW = 8;

  localparam int LAST_D0  = 0;
  localparam int LAST_D1  = 1;
  localparam int LAST_ALL = 2;
endpackage

// File: rtl/dma_dim_cnt.sv
// One dimension index counter: cleared by load, stepped by inc, and wrapped
// back to zero when stepped at its terminal count.
module dma_dim_cnt #(
  parameter int SW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [SW-1:0] size,
  output logic [SW-1:0] cnt,
  output logic          at_end
);
  logic [SW-1:0] cnt_q, cnt_d;

  assign at_end = (cnt_q == size);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (inc)
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dma_dim3.sv
// Three-dimensional DMA address generator: accepts one descriptor, then emits
// one address per accepted beat walking dim0, dim1, dim2 with signed steps.
module dma_dim3
  import dma_pkg::*;
#(
  parameter int AW  = DMA_AW,
  parameter int SW0 = 7,
  parameter int SW1 = 5,
  parameter int SW2 = 5,
  parameter int STW = DMA_STW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  base,
  input  logic [SW0-1:0] dim0_size,
  input  logic [STW-1:0] dim0_step,
  input  logic [SW1-1:0] dim1_size,
  input  logic [STW-1:0] dim1_step,
  input  logic [SW2-1:0] dim2_size,
  input  logic [STW-1:0] dim2_step,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic           abort,
  output logic [AW-1:0]  s_addr,
  output logic           s_first,
  output logic [2:0]     s_last,
  output logic           s_valid,
  input  logic           s_ready,
  output logic           busy
);
  dma_state_e     state_q;
  logic           start_ready_q, s_valid_q, busy_q, first_q;
  logic [AW-1:0]  addr_q, row_q, plane_q;
  logic [AW-1:0]  step0_q, step1_q, step2_q;
  logic [SW0-1:0] size0_q;
  logic [SW1-1:0] size1_q;
  logic [SW2-1:0] size2_q;

  logic           start_fire, beat;
  logic           at0, at1, at2;
  logic [SW0-1:0] i0;
  logic [SW1-1:0] i1;
  logic [SW2-1:0] i2;
  logic [AW-1:0]  row_next, plane_next;

  assign start_fire = (state_q == ST_IDLE) && start_valid;
  assign beat       = s_valid_q && s_ready;
  assign row_next   = row_q + step1_q;
  assign plane_next = plane_q + step2_q;

  dma_dim_cnt #(.SW(SW0)) u_cnt0 (
    .clk(clk), .rst_n(rst_n), .load(start_fire), .inc(beat),
    .size(size0_q), .cnt(i0), .at_end(at0)
  );
  dma_dim_cnt #(.SW(SW1)) u_cnt1 (
    .clk(clk), .rst_n(rst_n), .load(start_fire), .inc(beat && at0),
    .size(size1_q), .cnt(i1), .at_end(at1)
  );
  dma_dim_cnt #(.SW(SW2)) u_cnt2 (
    .clk(clk), .rst_n(rst_n), .load(start_fire), .inc(beat && at0 && at1),
    .size(size2_q), .cnt(i2), .at_end(at2)
  );

  // Flags are forced low outside RUN so IDLE never shows stale terminal counts.
  always_comb begin
    s_last           = '0;
    s_last[LAST_D0]  = s_valid_q && at0;
    s_last[LAST_D1]  = s_valid_q && at0 && at1;
    s_last[LAST_ALL] = s_valid_q && at0 && at1 && at2;
  end

  assign start_ready = start_ready_q;
  assign s_valid     = s_valid_q;
  assign busy        = busy_q;
  assign s_first     = first_q;
  assign s_addr      = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      start_ready_q <= 1'b1;
      s_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      first_q       <= 1'b0;
      addr_q        <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      step0_q       <= '0;
      step1_q       <= '0;
      step2_q       <= '0;
      size0_q       <= '0;
      size1_q       <= '0;
      size2_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            state_q       <= ST_RUN;
            start_ready_q <= 1'b0;
            s_valid_q     <= 1'b1;
            busy_q        <= 1'b1;
            first_q       <= 1'b1;
            addr_q        <= base;
            row_q         <= base;
            plane_q       <= base;
            step0_q       <= AW'($signed(dim0_step));
            step1_q       <= AW'($signed(dim1_step));
            step2_q       <= AW'($signed(dim2_step));
            size0_q       <= dim0_size;
            size1_q       <= dim1_size;
            size2_q       <= dim2_size;
          end
        end
        ST_RUN: begin
          if (beat) begin
            first_q <= 1'b0;
            if (!at0) begin
              addr_q <= addr_q + step0_q;
            end else if (!at1) begin
              addr_q <= row_next;
              row_q  <= row_next;
            end else if (!at2) begin
              addr_q  <= plane_next;
              row_q   <= plane_next;
              plane_q <= plane_next;
            end
          end
          if (abort || (beat && at0 && at1 && at2)) begin
            state_q       <= ST_IDLE;
            start_ready_q <= 1'b1;
            s_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_dim3.sv
// Self-checking bench for dma_dim3: expected beats come from a nested-loop
// arithmetic model (base + i2*step2 + i1*step1 + i0*step0, mod 2^AW).
module tb_dma_dim3;
  localparam int AW = 14, SW0 = 7, SW1 = 5, SW2 = 5, STW = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  base = '0;
  logic [SW0-1:0] dim0_size = '0;
  logic [STW-1:0] dim0_step = '0;
  logic [SW1-1:0] dim1_size = '0;
  logic [STW-1:0] dim1_step = '0;
  logic [SW2-1:0] dim2_size = '0;
  logic [STW-1:0] dim2_step = '0;
  logic           start_valid = 1'b0;
  logic           start_ready;
  logic           abort = 1'b0;
  logic [AW-1:0]  s_addr;
  logic           s_first;
  logic [2:0]     s_last;
  logic           s_valid;
  logic           s_ready = 1'b0;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  dma_dim3 #(.AW(AW), .SW0(SW0), .SW1(SW1), .SW2(SW2), .STW(STW)) dut (
    .clk(clk), .rst_n(rst_n), .base(base),
    .dim0_size(dim0_size), .dim0_step(dim0_step),
    .dim1_size(dim1_size), .dim1_step(dim1_step),
    .dim2_size(dim2_size), .dim2_step(dim2_step),
    .start_valid(start_valid), .start_ready(start_ready), .abort(abort),
    .s_addr(s_addr), .s_first(s_first), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_s_last"}, 32'(s_last), 32'd0);
  endtask

  // rmode: 0 = s_ready held high, 1 = toggling 1,0,1,0, 2 = random.
  // abort_after > 0: abort coincides with the handshake of that beat number.
  task automatic run_desc(input logic [AW-1:0] b, input int s0, input int st0,
                          input int s1, input int st1, input int s2, input int st2,
                          input int rmode, input int abort_after, input bit abort_at_start);
    logic [AW-1:0] ea[$];
    bit            ef[$];
    logic [2:0]    el[$];
    int            nexp, k, cyc;
    bit            rdy, l0, l1, l2;

    for (int i2 = 0; i2 <= s2; i2++)
      for (int i1 = 0; i1 <= s1; i1++)
        for (int i0 = 0; i0 <= s0; i0++) begin
          ea.push_back(AW'(int'(b) + i2 * st2 + i1 * st1 + i0 * st0));
          ef.push_back(i0 == 0 && i1 == 0 && i2 == 0);
          l0 = (i0 == s0);
          l1 = l0 && (i1 == s1);
          l2 = l1 && (i2 == s2);
          el.push_back({l2, l1, l0});
        end
    nexp = ea.size();
    if (abort_after > 0 && abort_after < nexp) nexp = abort_after;

    cyc = 0;
    while (start_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("start_ready_before_desc", 32'(start_ready), 32'd1);

    base        = b;
    dim0_size   = SW0'(s0);
    dim0_step   = STW'(st0);
    dim1_size   = SW1'(s1);
    dim1_step   = STW'(st1);
    dim2_size   = SW2'(s2);
    dim2_step   = STW'(st2);
    start_valid = 1'b1;
    abort       = abort_at_start;
    s_ready     = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    abort       = 1'b0;
    base        = AW'($urandom);
    dim0_size   = SW0'($urandom);
    dim0_step   = STW'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("start_ready_in_run", 32'(start_ready), 32'd0);

    k = 0;
    cyc = 0;
    while (k < nexp && cyc < 5000) begin
      chk("s_valid", 32'(s_valid), 32'd1);
      chk("s_addr", 32'(s_addr), 32'(ea[k]));
      chk("s_first", 32'(s_first), 32'(ef[k]));
      chk("s_last", 32'(s_last), 32'(el[k]));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      s_ready = rdy;
      abort   = rdy && (abort_after > 0) && (k == abort_after - 1);
      @(negedge clk);
      cyc++;
      if (rdy) k++;
    end
    chk("beats_completed", 32'(k), 32'(nexp));
    s_ready = 1'b0;
    abort   = 1'b0;
    chk_idle("after_transfer");
    $display("desc base=%0d sizes=%0d/%0d/%0d steps=%0d/%0d/%0d beats=%0d cycles=%0d",
             b, s0, s1, s2, st0, st1, st2, k, cyc);
  endtask

  initial begin
    // Reset hold, then idle with no start
    repeat (3) @(negedge clk);
    chk_idle("reset_hold");
    chk("reset_addr", 32'(s_addr), 32'd0);
    chk("reset_first", 32'(s_first), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("post_reset");
      chk("post_reset_addr", 32'(s_addr), 32'd0);
    end

    run_desc(14'd0, 9, 1, 4, 10, 0, 0, 0, 0, 1'b0);
    run_desc(14'd100, 1, 1, 1, 20, 1, 100, 1, 0, 1'b0);
    run_desc(14'd1, 2, -1, 0, 0, 0, 0, 0, 0, 1'b0);
    // All sizes zero; abort coinciding with the start handshake is ignored
    run_desc(14'd77, 0, 5, 0, 5, 0, 5, 0, 0, 1'b1);
    // Abort after three beats, then a fresh single-beat descriptor
    run_desc(14'd0, 9, 1, 4, 10, 0, 0, 0, 3, 1'b0);
    run_desc(14'd500, 0, 1, 0, 0, 0, 0, 0, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_desc(AW'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 255)) - 128,
               2, (t % 4 == 3) ? int'($urandom_range(1, 3)) : 0, 1'b0);
    end

    // Asynchronous reset in the middle of a transfer
    base = 14'd300;
    dim0_size = 7'd20;
    dim0_step = 8'd1;
    dim1_size = '0;
    dim2_size = '0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    s_ready = 1'b1;
    @(negedge clk);
    chk("pre_reset_valid", 32'(s_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_addr", 32'(s_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_ready = 1'b0;
    @(negedge clk);
    chk_idle("after_async_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
